// File: rtl/cotm32_csr_file.sv
// Machine-mode CSR file and trap/mret sequencer for the cotm32 core.
// Holds the M-mode CSRs and privilege mode, and resolves the trap vector and pending interrupt cause.
module cotm32_csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        mret_req,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_soft,
    output logic        irq_pending,
    output logic [31:0] irq_cause,
    output logic [31:0] trap_vector,
    output logic [31:0] mret_pc,
    output logic [1:0]  priv
);
    localparam logic [1:0]  CSR_OP_NONE = 2'd0;
    localparam logic [1:0]  CSR_OP_RW   = 2'd1;
    localparam logic [1:0]  CSR_OP_RS   = 2'd2;
    localparam logic [1:0]  CSR_OP_RC   = 2'd3;
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [31:0] IRQ_MASK      = 32'h0000_0888;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_M = 2'b11
    } priv_mode_t;

    priv_mode_t  priv_q, priv_d;
    logic        mst_mie_q, mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    logic [1:0]  mst_mpp_q, mst_mpp_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] mip_q, mip_d;

    logic [31:0] mstatus_val, old_val, new_val, irq_en;
    logic        addr_ok, mret_go, csr_we;

    always_comb begin
        mstatus_val        = 32'h0;
        mstatus_val[3]     = mst_mie_q;
        mstatus_val[7]     = mst_mpie_q;
        mstatus_val[12:11] = mst_mpp_q;
        addr_ok = 1'b1;
        old_val = 32'h0;
        case (csr_addr)
            ADDR_MSTATUS:  old_val = mstatus_val;
            ADDR_MIE:      old_val = mie_q;
            ADDR_MTVEC:    old_val = mtvec_q;
            ADDR_MSCRATCH: old_val = mscratch_q;
            ADDR_MEPC:     old_val = mepc_q;
            ADDR_MCAUSE:   old_val = mcause_q;
            ADDR_MTVAL:    old_val = mtval_q;
            ADDR_MIP:      old_val = mip_q;
            default:       addr_ok = 1'b0;
        endcase
        case (csr_op)
            CSR_OP_RW: new_val = csr_wdata;
            CSR_OP_RS: new_val = old_val | csr_wdata;
            CSR_OP_RC: new_val = old_val & ~csr_wdata;
            default:   new_val = old_val;
        endcase
        csr_illegal = (csr_op != CSR_OP_NONE) && (!addr_ok || priv_q == PRIV_U);
        csr_rdata   = (csr_op != CSR_OP_NONE && addr_ok) ? old_val : 32'h0;
    end

    // Priority: trap, then mret (M-mode only), then CSR write.
    assign mret_go = mret_req && (priv_q == PRIV_M);
    assign csr_we  = (csr_op != CSR_OP_NONE) && !csr_illegal && !trap_req && !mret_go;

    always_comb begin
        priv_d     = priv_q;
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mst_mpp_d  = mst_mpp_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mip_d      = {20'h0, irq_ext, 3'b000, irq_timer, 3'b000, irq_soft, 3'b000};
        if (trap_req) begin
            mepc_d     = trap_pc & ~32'h3;
            mcause_d   = trap_cause;
            mtval_d    = trap_val;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
            mst_mpp_d  = priv_q;
            priv_d     = PRIV_M;
        end else if (mret_go) begin
            priv_d     = priv_mode_t'(mst_mpp_q);
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
            mst_mpp_d  = PRIV_U;
        end else if (csr_we) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mst_mie_d  = new_val[3];
                    mst_mpie_d = new_val[7];
                    if (new_val[12:11] == 2'b00 || new_val[12:11] == 2'b11)
                        mst_mpp_d = new_val[12:11];
                end
                ADDR_MIE:      mie_d = new_val & IRQ_MASK;
                ADDR_MTVEC: begin
                    mtvec_d[31:2] = new_val[31:2];
                    if (new_val[1:0] == 2'b00 || (new_val[1:0] == 2'b01 && VECTORED_EN))
                        mtvec_d[1:0] = new_val[1:0];
                end
                ADDR_MSCRATCH: mscratch_d = new_val;
                ADDR_MEPC:     mepc_d = new_val & ~32'h3;
                ADDR_MCAUSE:   mcause_d = new_val;
                ADDR_MTVAL:    mtval_d = new_val;
                default:       ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            priv_q     <= PRIV_M;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mst_mpp_q  <= 2'b11;
            mie_q      <= 32'h0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mtval_q    <= 32'h0;
            mip_q      <= 32'h0;
        end else begin
            priv_q     <= priv_d;
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mst_mpp_q  <= mst_mpp_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mip_q      <= mip_d;
        end
    end

    always_comb begin
        irq_en      = mip_q & mie_q;
        irq_pending = (|irq_en) && (priv_q == PRIV_U || mst_mie_q);
        irq_cause   = 32'h0;
        if (irq_pending) begin
            if (irq_en[11])     irq_cause = {1'b1, 31'd11};
            else if (irq_en[3]) irq_cause = {1'b1, 31'd3};
            else                irq_cause = {1'b1, 31'd7};
        end
        trap_vector = {mtvec_q[31:2], 2'b00};
        if (mtvec_q[1:0] == 2'b01 && trap_cause[31])
            trap_vector = {mtvec_q[31:2], 2'b00} + {trap_cause[29:0], 2'b00};
    end

    assign mret_pc = mepc_q;
    assign priv    = priv_q;

endmodule

// File: tb/tb_cotm32_csr_file.sv
// Directed bench for cotm32_csr_file: reset values, WARL masks, interrupts, trap/mret and event priority.
module tb_cotm32_csr_file;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        mret_req;
    logic        irq_ext, irq_timer, irq_soft;
    logic        irq_pending;
    logic [31:0] irq_cause;
    logic [31:0] trap_vector;
    logic [31:0] mret_pc;
    logic [1:0]  priv;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_RW   = 2'd1;
    localparam logic [1:0] OP_RS   = 2'd2;
    localparam logic [1:0] OP_RC   = 2'd3;

    cotm32_csr_file #(.MTVEC_RESET(32'h0000_0000), .VECTORED_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val),
        .mret_req(mret_req),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
        .irq_pending(irq_pending), .irq_cause(irq_cause),
        .trap_vector(trap_vector), .mret_pc(mret_pc), .priv(priv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data);
        csr_op = op; csr_addr = addr; csr_wdata = data;
        step();
        csr_op = OP_NONE; csr_wdata = 32'h0;
    endtask

    // csrrs x0: reads without changing state
    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_op = OP_RS; csr_addr = addr; csr_wdata = 32'h0;
        #1;
        chk(tag, csr_rdata, exp);
        step();
        csr_op = OP_NONE;
    endtask

    task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] val);
        trap_req = 1'b1; trap_cause = cause; trap_pc = pc; trap_val = val;
        step();
        trap_req = 1'b0; trap_cause = 32'h0;
    endtask

    task automatic do_mret();
        mret_req = 1'b1;
        step();
        mret_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; csr_op = OP_NONE; csr_addr = 12'h0; csr_wdata = 32'h0;
        trap_req = 1'b0; trap_cause = 32'h0; trap_pc = 32'h0; trap_val = 32'h0;
        mret_req = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_priv", {30'h0, priv}, 32'h3);
        chk("rst_irq_pending", {31'h0, irq_pending}, 32'h0);
        chk("rst_irq_cause", irq_cause, 32'h0);
        chk("rst_mret_pc", mret_pc, 32'h0);
        chk("rst_trap_vector", trap_vector, 32'h0);
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mie", 12'h304, 32'h0);
        rd("rst_mtvec", 12'h305, 32'h0);
        rd("rst_mscratch", 12'h340, 32'h0);
        rd("rst_mepc", 12'h341, 32'h0);
        rd("rst_mcause", 12'h342, 32'h0);
        rd("rst_mtval", 12'h343, 32'h0);
        rd("rst_mip", 12'h344, 32'h0);

        csr_op = OP_RS; csr_addr = 12'h300; csr_wdata = 32'h0; #1;
        chk("legal_illegal", {31'h0, csr_illegal}, 32'h0);
        csr_addr = 12'h7C0; #1;
        chk("unimpl_illegal", {31'h0, csr_illegal}, 32'h1);
        chk("unimpl_rdata", csr_rdata, 32'h0);
        csr_op = OP_NONE; csr_addr = 12'h300; #1;
        chk("none_illegal", {31'h0, csr_illegal}, 32'h0);
        chk("none_rdata", csr_rdata, 32'h0);
        step();

        wr(OP_RW, 12'h305, 32'h8000_0003);
        rd("mtvec_mode11", 12'h305, 32'h8000_0000);
        wr(OP_RW, 12'h305, 32'h8000_0101);
        rd("mtvec_vec", 12'h305, 32'h8000_0101);
        trap_cause = 32'h8000_0007; #1;
        chk("vec_timer", trap_vector, 32'h8000_011C);
        trap_cause = 32'h0000_0002; #1;
        chk("vec_exc", trap_vector, 32'h8000_0100);
        trap_cause = 32'h0;

        wr(OP_RS, 12'h300, 32'hFFFF_FFFF);
        rd("mstatus_rs", 12'h300, 32'h0000_1888);
        wr(OP_RC, 12'h300, 32'h0000_0800);
        rd("mstatus_mpp01", 12'h300, 32'h0000_1888);
        wr(OP_RW, 12'h341, 32'h0000_1235);
        rd("mepc_align", 12'h341, 32'h0000_1234);
        chk("mret_pc", mret_pc, 32'h0000_1234);
        csr_op = OP_RW; csr_addr = 12'h344; csr_wdata = 32'hFFFF_FFFF; #1;
        chk("mip_wr_illegal", {31'h0, csr_illegal}, 32'h0);
        step(); csr_op = OP_NONE;
        rd("mip_ro", 12'h344, 32'h0);

        wr(OP_RW, 12'h304, 32'hFFFF_FFFF);
        rd("mie_mask", 12'h304, 32'h0000_0888);
        irq_timer = 1'b1; irq_soft = 1'b1; #1;
        chk("irq_latency", {31'h0, irq_pending}, 32'h0);
        step();
        chk("irq_pend_ts", {31'h0, irq_pending}, 32'h1);
        chk("irq_cause_ts", irq_cause, 32'h8000_0003);
        irq_ext = 1'b1;
        step();
        chk("irq_cause_ext", irq_cause, 32'h8000_000B);
        rd("mip_lines", 12'h344, 32'h0000_0888);
        wr(OP_RC, 12'h300, 32'h0000_0008);
        chk("irq_masked_m", {31'h0, irq_pending}, 32'h0);
        wr(OP_RS, 12'h300, 32'h0000_0008);
        irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0;
        step();

        do_trap(32'h0000_0002, 32'h0000_0104, 32'h0000_DEAD);
        chk("trap_priv", {30'h0, priv}, 32'h3);
        rd("trap_mepc", 12'h341, 32'h0000_0104);
        rd("trap_mcause", 12'h342, 32'h0000_0002);
        rd("trap_mtval", 12'h343, 32'h0000_DEAD);
        rd("trap_mstatus", 12'h300, 32'h0000_1880);
        wr(OP_RC, 12'h300, 32'h0000_1800);
        rd("mpp_00", 12'h300, 32'h0000_0080);
        do_mret();
        chk("mret_priv_u", {30'h0, priv}, 32'h0);
        csr_op = OP_RW; csr_addr = 12'h340; csr_wdata = 32'h77; #1;
        chk("u_illegal", {31'h0, csr_illegal}, 32'h1);
        step(); csr_op = OP_NONE;
        do_trap(32'h0000_0008, 32'h0000_0300, 32'h0);
        chk("u_trap_priv", {30'h0, priv}, 32'h3);
        rd("u_trap_mstatus", 12'h300, 32'h0000_0080);
        rd("u_wr_dropped", 12'h340, 32'h0);
        wr(OP_RC, 12'h300, 32'h0000_0080);
        do_mret();
        chk("mret2_priv_u", {30'h0, priv}, 32'h0);
        irq_soft = 1'b1;
        step();
        chk("u_irq_pend", {31'h0, irq_pending}, 32'h1);
        chk("u_irq_cause", irq_cause, 32'h8000_0003);
        irq_soft = 1'b0;
        step();

        do_trap(32'h0000_0008, 32'h0000_0400, 32'h0);
        rd("pre_sim_mstatus", 12'h300, 32'h0000_0000);
        trap_req = 1'b1; trap_cause = 32'h0000_000B; trap_pc = 32'h0000_0203; trap_val = 32'h55;
        mret_req = 1'b1; csr_op = OP_RW; csr_addr = 12'h340; csr_wdata = 32'h5;
        step();
        trap_req = 1'b0; trap_cause = 32'h0; mret_req = 1'b0; csr_op = OP_NONE;
        chk("sim_priv", {30'h0, priv}, 32'h3);
        rd("sim_mscratch", 12'h340, 32'h0);
        rd("sim_mepc", 12'h341, 32'h0000_0200);
        rd("sim_mcause", 12'h342, 32'h0000_000B);
        rd("sim_mtval", 12'h343, 32'h0000_0055);
        rd("sim_mstatus", 12'h300, 32'h0000_1800);

        irq_ext = 1'b1;
        rst_n = 1'b0; trap_req = 1'b1; trap_cause = 32'h0000_0002; trap_pc = 32'h0000_0500;
        step();
        trap_req = 1'b0; trap_cause = 32'h0; irq_ext = 1'b0; rst_n = 1'b1; #1;
        chk("rst2_priv", {30'h0, priv}, 32'h3);
        chk("rst2_irq_pending", {31'h0, irq_pending}, 32'h0);
        chk("rst2_mret_pc", mret_pc, 32'h0);
        chk("rst2_trap_vector", trap_vector, 32'h0);
        rd("rst2_mstatus", 12'h300, 32'h0000_1800);
        rd("rst2_mie", 12'h304, 32'h0);
        rd("rst2_mtvec", 12'h305, 32'h0);
        rd("rst2_mcause", 12'h342, 32'h0);
        rd("rst2_mtval", 12'h343, 32'h0);
        rd("rst2_mip", 12'h344, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
